// File: rtl/guess_scorer.sv
// Sequential Mastermind hint engine: counts exact-position (green) and
// colour-only (yellow) matches using a single colour comparator per cycle.
module guess_scorer #(
  parameter int COLOR_W  = 5,
  parameter int POS_W    = 5,
  parameter int MAX_PINS = 20
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic [POS_W-1:0]            i_pins_count,
  input  logic [MAX_PINS*COLOR_W-1:0] i_guess,
  input  logic [MAX_PINS*COLOR_W-1:0] i_secret,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [POS_W-1:0]            o_green,
  output logic [POS_W-1:0]            o_yellow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int IDX_W = (MAX_PINS > 1) ? $clog2(MAX_PINS) : 1;
  localparam logic [POS_W-1:0] MAX_N = POS_W'(MAX_PINS);

  logic [1:0]         r_state;
  logic [COLOR_W-1:0] r_g [MAX_PINS];
  logic [COLOR_W-1:0] r_s [MAX_PINS];
  logic [POS_W-1:0]   r_n;
  logic [POS_W:0]     r_i;
  logic [POS_W:0]     r_j;
  logic [MAX_PINS-1:0] r_used_g;
  logic [MAX_PINS-1:0] r_used_s;
  logic [POS_W-1:0]   r_gc;
  logic [POS_W-1:0]   r_yc;
  logic [POS_W-1:0]   r_green;
  logic [POS_W-1:0]   r_yellow;

  logic [POS_W-1:0]   w_n_clamped;
  logic [POS_W:0]     w_n_ext;
  logic [POS_W:0]     w_i_inc;
  logic [POS_W:0]     w_j_inc;
  logic [IDX_W-1:0]   w_i_idx;
  logic [IDX_W-1:0]   w_j_idx;
  logic [COLOR_W-1:0] w_gi;
  logic [COLOR_W-1:0] w_si;
  logic [COLOR_W-1:0] w_sj;

  assign w_n_clamped = (i_pins_count > MAX_N) ? MAX_N : i_pins_count;
  assign w_n_ext     = {1'b0, r_n};
  assign w_i_inc     = r_i + 1'b1;
  assign w_j_inc     = r_j + 1'b1;
  assign w_i_idx     = r_i[IDX_W-1:0];
  assign w_j_idx     = r_j[IDX_W-1:0];
  assign w_gi        = r_g[w_i_idx];
  assign w_si        = r_s[w_i_idx];
  assign w_sj        = r_s[w_j_idx];

  // Held result is shown directly from the counters during the DONE cycle.
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_green  = o_done ? r_gc : r_green;
  assign o_yellow = o_done ? r_yc : r_yellow;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      for (int k = 0; k < MAX_PINS; k++) begin
        r_g[k] <= '0;
        r_s[k] <= '0;
      end
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_used_g <= '0;
      r_used_s <= '0;
      r_gc     <= '0;
      r_yc     <= '0;
      r_green  <= '0;
      r_yellow <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < MAX_PINS; k++) begin
              r_g[k] <= i_guess[k*COLOR_W +: COLOR_W];
              r_s[k] <= i_secret[k*COLOR_W +: COLOR_W];
            end
            r_n      <= w_n_clamped;
            r_i      <= '0;
            r_j      <= '0;
            r_used_g <= '0;
            r_used_s <= '0;
            r_gc     <= '0;
            r_yc     <= '0;
            r_state  <= (w_n_clamped == '0) ? S_DONE : S_GREEN;
          end
        end

        S_GREEN: begin
          if (w_gi == w_si) begin
            r_gc              <= r_gc + 1'b1;
            r_used_g[w_i_idx] <= 1'b1;
            r_used_s[w_i_idx] <= 1'b1;
          end
          if (w_i_inc == w_n_ext) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_YELLOW;
          end else begin
            r_i <= w_i_inc;
          end
        end

        // Scan secret from index 0 so the lowest free matching pin is consumed.
        S_YELLOW: begin
          if (r_used_g[w_i_idx] || (r_j == w_n_ext)) begin
            r_i <= w_i_inc;
            r_j <= '0;
            if (w_i_inc == w_n_ext) r_state <= S_DONE;
          end else if (!r_used_s[w_j_idx] && (w_gi == w_sj)) begin
            r_yc              <= r_yc + 1'b1;
            r_used_s[w_j_idx] <= 1'b1;
            r_i               <= w_i_inc;
            r_j               <= '0;
            if (w_i_inc == w_n_ext) r_state <= S_DONE;
          end else begin
            r_j <= w_j_inc;
          end
        end

        S_DONE: begin
          r_green  <= r_gc;
          r_yellow <= r_yc;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: scoreboard of expected score and latency,
// checked with immediate assertions when done pulses.
module tb_guess_scorer;

  localparam int COLOR_W  = 5;
  localparam int POS_W    = 5;
  localparam int MAX_PINS = 20;
  localparam int VW       = MAX_PINS*COLOR_W;
  localparam int LIMIT    = 600;

  typedef struct {
    int green;
    int yellow;
    int cycle;
  } exp_t;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_start;
  logic [POS_W-1:0]  i_pins_count;
  logic [VW-1:0]     i_guess;
  logic [VW-1:0]     i_secret;
  logic              o_busy;
  logic              o_done;
  logic [POS_W-1:0]  o_green;
  logic [POS_W-1:0]  o_yellow;

  int   n_asserts;
  int   n_fails;
  exp_t sb[$];
  int   prev_green;
  int   prev_yellow;

  guess_scorer #(.COLOR_W(COLOR_W), .POS_W(POS_W), .MAX_PINS(MAX_PINS)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (i_start),
    .i_pins_count (i_pins_count),
    .i_guess      (i_guess),
    .i_secret     (i_secret),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_green      (o_green),
    .o_yellow     (o_yellow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW-1:0] v;
    v = '0;
    v[0*COLOR_W +: COLOR_W] = COLOR_W'(a);
    v[1*COLOR_W +: COLOR_W] = COLOR_W'(b);
    v[2*COLOR_W +: COLOR_W] = COLOR_W'(c);
    v[3*COLOR_W +: COLOR_W] = COLOR_W'(d);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill(input int c);
    logic [VW-1:0] v;
    for (int k = 0; k < MAX_PINS; k++) v[k*COLOR_W +: COLOR_W] = COLOR_W'(c);
    return v;
  endfunction

  // Launch one score; when disturb is set, inputs are scrambled while busy
  // and the previous result must stay on the outputs until done.
  task automatic run_case(input string tag, input int n, input logic [VW-1:0] g,
                          input logic [VW-1:0] s, input int eg, input int ey,
                          input int ec, input bit disturb);
    exp_t e;
    int   cyc;
    e.green = eg; e.yellow = ey; e.cycle = ec;
    sb.push_back(e);
    @(negedge i_clk);
    i_pins_count = POS_W'(n);
    i_guess      = g;
    i_secret     = s;
    i_start      = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (!o_done && cyc < LIMIT) begin
      check({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (disturb) begin
        check({tag, "_held_g"}, 32'(o_green), 32'(prev_green));
        check({tag, "_held_y"}, 32'(o_yellow), 32'(prev_yellow));
        i_start      = 1'($urandom_range(0, 1));
        i_pins_count = POS_W'($urandom_range(0, 31));
        i_guess      = VW'({$urandom(), $urandom(), $urandom(), $urandom()});
        i_secret     = VW'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    e = sb.pop_front();
    check({tag, "_done_seen"}, 32'(o_done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
    check({tag, "_cycle"}, 32'(cyc), 32'(e.cycle));
    check({tag, "_green"}, 32'(o_green), 32'(e.green));
    check({tag, "_yellow"}, 32'(o_yellow), 32'(e.yellow));
    @(posedge i_clk); #1;
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
    check({tag, "_hold_g"}, 32'(o_green), 32'(e.green));
    check({tag, "_hold_y"}, 32'(o_yellow), 32'(e.yellow));
    prev_green  = e.green;
    prev_yellow = e.yellow;
  endtask

  initial begin
    int cyc;
    n_asserts    = 0;
    n_fails      = 0;
    prev_green   = 0;
    prev_yellow  = 0;
    i_reset_n    = 1'b0;
    i_start      = 1'b0;
    i_pins_count = '0;
    i_guess      = '0;
    i_secret     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_green", 32'(o_green), 32'd0);
    check("rst_yellow", 32'(o_yellow), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check("idle_busy", 32'(o_busy), 32'd0);

    run_case("exact", 4, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4, 0, 9, 1'b0);
    run_case("perm", 4, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0, 4, 15, 1'b0);
    run_case("dups", 4, pack4(0, 1, 0, 5), pack4(0, 0, 1, 1), 1, 2, 16, 1'b0);
    run_case("n0", 0, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, 0, 1, 1'b0);
    run_case("n3", 3, pack4(2, 2, 3, 0), pack4(2, 3, 3, 0), 2, 0, 10, 1'b0);
    run_case("clamp", 31, fill(7), fill(7), 20, 0, 41, 1'b0);
    run_case("worst", 20, fill(1), fill(2), 0, 0, 441, 1'b1);

    // Abort partway through a worst-case score.
    run_case("pre", 4, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4, 0, 9, 1'b0);
    @(negedge i_clk);
    i_pins_count = POS_W'(20);
    i_guess      = fill(1);
    i_secret     = fill(2);
    i_start      = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    check("mid_busy_before", 32'(o_busy), 32'd1);
    check("mid_green_before", 32'(o_green), 32'd4);
    i_reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(o_busy), 32'd0);
    check("mid_done", 32'(o_done), 32'd0);
    check("mid_green", 32'(o_green), 32'd0);
    check("mid_yellow", 32'(o_yellow), 32'd0);
    repeat (3) begin
      @(posedge i_clk); #1;
      check("mid_no_done", 32'(o_done), 32'd0);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check("post_rst_idle", 32'(o_busy), 32'd0);
    prev_green  = 0;
    prev_yellow = 0;
    run_case("fresh", 4, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0, 4, 15, 1'b0);
    run_case("b2b", 4, pack4(0, 1, 0, 5), pack4(0, 0, 1, 1), 1, 2, 16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
